// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game controller.
package simon_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StPlayOn,
        StPlayOff,
        StWaitIn,
        StLose,
        StWin
    } simon_state_e;

    typedef logic [1:0] colour_t;

    // Map a colour code to its one-hot LED/button pattern.
    function automatic logic [3:0] onehot(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), loaded with seed on reset, steps when en=1.
module simon_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign q    = r_q;

    // Shift register: reload seed on reset, otherwise shift in feedback when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon memory-game controller: grows a random colour sequence, plays it back,
// then checks the player's replay against it.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN       = 9,
    parameter int unsigned ON_TICKS      = 500,
    parameter int unsigned OFF_TICKS     = 250,
    parameter int unsigned TIMEOUT_TICKS = 3000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] seq_led,
    output logic [3:0] score,
    output logic       display_loss,
    output logic       win,
    output logic       busy
);

    localparam int unsigned TMAX01   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TIMER_MX = (TMAX01 > TIMEOUT_TICKS) ? TMAX01 : TIMEOUT_TICKS;
    localparam int unsigned TIMER_W  = $clog2(TIMER_MX + 1);

    simon_state_e       r_state, w_state_d;
    colour_t            r_mem [MAX_LEN];
    colour_t            w_mem_d [MAX_LEN];
    logic [3:0]         r_len, w_len_d;
    logic [3:0]         r_idx, w_idx_d;
    logic [TIMER_W-1:0] r_timer, w_timer_d, w_timer_inc;
    logic [3:0]         r_score, w_score_d;
    logic [3:0]         r_seq_led, w_seq_led_d;
    logic               r_loss, r_win, r_busy;
    logic               w_mem_we, w_lfsr_en;
    logic [7:0]         w_lfsr;
    colour_t            w_exp_col, w_next_col;
    logic               w_unused_lfsr;

    assign w_unused_lfsr = ^w_lfsr[7:2];
    assign w_timer_inc   = r_timer + TIMER_W'(1);

    simon_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (w_lfsr_en),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    // Colour expected at the current index (mux avoids index-width issues for small MAX_LEN).
    always_comb begin
        w_exp_col = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (r_idx == 4'(i)) w_exp_col = r_mem[i];
        end
    end

    // Next-state, datapath updates and timer control.
    always_comb begin
        w_state_d = r_state;
        w_len_d   = r_len;
        w_idx_d   = r_idx;
        w_timer_d = r_timer;
        w_score_d = r_score;
        w_mem_we  = 1'b0;
        w_lfsr_en = 1'b0;

        unique case (r_state)
            StIdle, StLose, StWin: begin
                // LFSR free-runs only while idle so start timing seeds the sequence.
                w_lfsr_en = (r_state == StIdle);
                if (start) begin
                    w_state_d = StAdd;
                    w_len_d   = '0;
                    w_score_d = '0;
                end
            end
            StAdd: begin
                w_mem_we  = 1'b1;
                w_len_d   = r_len + 4'd1;
                w_lfsr_en = 1'b1;
                w_idx_d   = '0;
                w_state_d = StPlayOn;
            end
            StPlayOn: begin
                if (tick) begin
                    w_timer_d = w_timer_inc;
                    if (w_timer_inc == TIMER_W'(ON_TICKS)) w_state_d = StPlayOff;
                end
            end
            StPlayOff: begin
                if (tick) begin
                    w_timer_d = w_timer_inc;
                    if (w_timer_inc == TIMER_W'(OFF_TICKS)) begin
                        if (r_idx == r_len - 4'd1) begin
                            w_idx_d   = '0;
                            w_state_d = StWaitIn;
                        end else begin
                            w_idx_d   = r_idx + 4'd1;
                            w_state_d = StPlayOn;
                        end
                    end
                end
            end
            StWaitIn: begin
                // A press wins over a timeout landing on the same cycle.
                if (btn != 4'b0000) begin
                    if (btn == onehot(w_exp_col)) begin
                        if (r_idx == r_len - 4'd1) begin
                            w_score_d = r_len;
                            w_state_d = (r_len == 4'(MAX_LEN)) ? StWin : StAdd;
                        end else begin
                            w_idx_d   = r_idx + 4'd1;
                            w_timer_d = '0;
                        end
                    end else begin
                        w_state_d = StLose;
                    end
                end else if (tick) begin
                    w_timer_d = w_timer_inc;
                    if (w_timer_inc == TIMER_W'(TIMEOUT_TICKS)) w_state_d = StLose;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Timer restarts on every state entry.
        if (w_state_d != r_state) w_timer_d = '0;
    end

    // Next contents of the colour array (new colour appended in ADD).
    always_comb begin
        w_mem_d = r_mem;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (w_mem_we && (r_len == 4'(i))) w_mem_d[i] = w_lfsr[1:0];
        end
    end

    // Registered LED pattern follows the next state so it lines up with PLAY_ON.
    always_comb begin
        w_next_col = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (w_idx_d == 4'(i)) w_next_col = w_mem_d[i];
        end
        w_seq_led_d = (w_state_d == StPlayOn) ? onehot(w_next_col) : 4'b0000;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_len     <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_score   <= '0;
            r_seq_led <= '0;
            r_loss    <= 1'b0;
            r_win     <= 1'b0;
            r_busy    <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) r_mem[i] <= '0;
        end else begin
            r_state   <= w_state_d;
            r_len     <= w_len_d;
            r_idx     <= w_idx_d;
            r_timer   <= w_timer_d;
            r_score   <= w_score_d;
            r_seq_led <= w_seq_led_d;
            r_loss    <= (w_state_d == StLose);
            r_win     <= (w_state_d == StWin);
            r_busy    <= !((w_state_d == StIdle) || (w_state_d == StLose) ||
                           (w_state_d == StWin));
            r_mem     <= w_mem_d;
        end
    end

    assign seq_led      = r_seq_led;
    assign score        = r_score;
    assign display_loss = r_loss;
    assign win          = r_win;
    assign busy         = r_busy;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Self-checking bench for simon_game_ctrl (MAX_LEN=3, ON=2, OFF=1, TIMEOUT=5, tick every cycle).
module tb_simon_game_ctrl;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b1;
    logic       start = 1'b0;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] seq_led, score;
    logic       display_loss, win, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_lfsr;
    logic [1:0] m_mem [3];
    int         m_len;
    logic [3:0] m_score;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [3:0] btn;
        logic [3:0] led;
        logic [3:0] score;
        logic       loss;
        logic       win;
        logic       busy;
    } vec_t;

    vec_t vecs [16];

    simon_game_ctrl #(
        .MAX_LEN       (3),
        .ON_TICKS      (2),
        .OFF_TICKS     (1),
        .TIMEOUT_TICKS (5),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .btn          (btn),
        .seq_led      (seq_led),
        .score        (score),
        .display_loss (display_loss),
        .win          (win),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [7:0] lfsr_nx(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] c);
        logic [3:0] r;
        r    = 4'b0000;
        r[c] = 1'b1;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] led, input logic [3:0] sc,
                           input logic loss, input logic w, input logic b);
        chk({tag, ".seq_led"}, {4'b0, seq_led}, {4'b0, led});
        chk({tag, ".score"}, {4'b0, score}, {4'b0, sc});
        chk({tag, ".display_loss"}, {7'b0, display_loss}, {7'b0, loss});
        chk({tag, ".win"}, {7'b0, win}, {7'b0, w});
        chk({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
    endtask

    // Pulse start; the ADD state must be visible afterwards.
    task automatic start_game(input string tag, input bit from_idle);
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (from_idle) m_lfsr = lfsr_nx(m_lfsr);
        m_len   = 0;
        m_score = 4'd0;
        chk_all(tag, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // From ADD: append a colour, check the full playback, end in WAIT_IN.
    task automatic play(input string tag);
        m_mem[m_len] = m_lfsr[1:0];
        m_lfsr       = lfsr_nx(m_lfsr);
        m_len++;
        for (int i = 0; i < m_len; i++) begin
            cyc();
            chk_all({tag, ".on0"}, oh(m_mem[i]), m_score, 1'b0, 1'b0, 1'b1);
            cyc();
            chk_all({tag, ".on1"}, oh(m_mem[i]), m_score, 1'b0, 1'b0, 1'b1);
            cyc();
            chk_all({tag, ".off"}, 4'b0000, m_score, 1'b0, 1'b0, 1'b1);
        end
        cyc();
        chk_all({tag, ".wait"}, 4'b0000, m_score, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic press(input logic [3:0] b);
        btn = b;
        cyc();
        btn = 4'b0000;
    endtask

    // Replay the whole sequence correctly.
    task automatic replay_ok(input string tag);
        for (int i = 0; i < m_len; i++) begin
            press(oh(m_mem[i]));
            if (i < m_len - 1) begin
                chk_all({tag, ".mid"}, 4'b0000, m_score, 1'b0, 1'b0, 1'b1);
            end else begin
                m_score = 4'(m_len);
                if (m_len == 3) chk_all({tag, ".win"}, 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0);
                else            chk_all({tag, ".next"}, 4'b0000, m_score, 1'b0, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        logic [1:0] wrong;

        // Seed A5 -> 4A at start edge (mem0=2), 95 at ADD1 (mem1=1), 2A at ADD2.
        //            rst  st   btn      led      sc    loss win busy
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'b0001, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0010, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 4'b0000, 4'b0010, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b1};

        for (int v = 0; v < 16; v++) begin
            rst   = vecs[v].rst;
            start = vecs[v].start;
            btn   = vecs[v].btn;
            cyc();
            chk_all($sformatf("vec%0d", v), vecs[v].led, vecs[v].score, vecs[v].loss,
                    vecs[v].win, vecs[v].busy);
        end
        rst   = 1'b0;
        start = 1'b0;
        btn   = 4'b0000;

        // Model state after the table: two rounds stored, now in ADD of round 3.
        m_lfsr   = lfsr_nx(lfsr_nx(lfsr_nx(8'hA5)));
        m_mem[0] = 2'd2;
        m_mem[1] = 2'd1;
        m_len    = 2;
        m_score  = 4'd2;

        play("r3");
        replay_ok("r3");
        cyc();
        chk_all("win_hold", 4'b0000, 4'd3, 1'b0, 1'b1, 1'b0);

        // Wrong colour on press 2 of round 2.
        start_game("g2", 1'b0);
        play("g2r1");
        replay_ok("g2r1");
        play("g2r2");
        press(oh(m_mem[0]));
        chk_all("g2p1", 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1);
        wrong = m_mem[1] + 2'd1;
        press(oh(wrong));
        chk_all("g2lose", 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_all("g2hold", 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0);

        // Multi-bit first press loses.
        start_game("g3", 1'b0);
        play("g3r1");
        press(4'b0011);
        chk_all("g3multi", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0);

        // No press for 5 ticks loses.
        start_game("g4", 1'b0);
        play("g4r1");
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_all("g4wait", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        cyc();
        chk_all("g4timeout", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0);

        // Press on the 5th tick is accepted.
        start_game("g5", 1'b0);
        play("g5r1");
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_all("g5wait", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1);
        end
        press(oh(m_mem[0]));
        m_score = 4'd1;
        chk_all("g5late", 4'b0000, 4'd1, 1'b0, 1'b0, 1'b1);

        // Reset during PLAY_ON of round 2, with start and btn also asserted.
        m_mem[1] = m_lfsr[1:0];
        m_lfsr   = lfsr_nx(m_lfsr);
        m_len    = 2;
        cyc();
        chk_all("g5on", oh(m_mem[0]), 4'd1, 1'b0, 1'b0, 1'b1);
        rst   = 1'b1;
        start = 1'b1;
        btn   = 4'b1111;
        cyc();
        rst   = 1'b0;
        start = 1'b0;
        btn   = 4'b0000;
        m_lfsr  = 8'hA5;
        m_score = 4'd0;
        chk_all("rst", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        m_lfsr = lfsr_nx(m_lfsr);
        chk_all("rst_idle", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);

        // Fresh game after reset: colour follows the free-running idle LFSR.
        start_game("g6", 1'b1);
        play("g6r1");
        replay_ok("g6r1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 9: sequence length that wins the game (1..15).
REQ-002 SHALL have parameter ON_TICKS, default 500: tick count each playback LED stays lit (>=1).
REQ-003 SHALL have parameter OFF_TICKS, default 250: tick count of the dark gap after each playback LED (>=1).
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 3000: maximum ticks allowed between presses in WAIT_IN (>=1).
REQ-005 SHALL have parameter LFSR_SEED, default 8'hA5: nonzero 8-bit LFSR reset value.
REQ-006 clk  in  1  single system clock; all logic on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle timing strobe; all timers advance only on cycles where tick=1.
REQ-009 start  in  1  one-cycle pulse; begins a new game.
REQ-010 btn  in  4  debounced, one-cycle press pulses, one bit per colour.
REQ-011 seq_led  out  4  one-hot playback pattern for the LED/display block.
REQ-012 score  out  4  completed rounds, 0..MAX_LEN.
REQ-013 display_loss  out  1  high while in LOSE.
REQ-014 win  out  1  high while in WIN.
REQ-015 busy  out  1  high in every state except IDLE, LOSE and WIN.

Function
REQ-016 Every output SHALL be registered.
REQ-017 States SHALL be IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_IN, LOSE and WIN.
REQ-018 Storage SHALL be a MAX_LEN x 2-bit colour array plus a length register len (0..MAX_LEN).
REQ-019 An index register idx and a tick timer SHALL be kept; the timer SHALL clear on every state entry.
REQ-020 start in IDLE, LOSE or WIN SHALL, next cycle: clear len and score, deassert display_loss/win, enter ADD.
REQ-021 start in any other state SHALL be ignored.
REQ-022 ADD (one cycle) SHALL write lfsr[1:0] at index len, then increment len.
REQ-023 ADD SHALL also step the LFSR, set idx=0 and enter PLAY_ON.
REQ-024 PLAY_ON SHALL drive seq_led = onehot(mem[idx]).
REQ-025 PLAY_ON SHALL enter PLAY_OFF on the tick that brings the timer to ON_TICKS.
REQ-026 PLAY_OFF SHALL drive seq_led=0.
REQ-027 When the timer reaches OFF_TICKS, PLAY_OFF SHALL enter WAIT_IN with idx=0 if idx==len-1.
REQ-028 Otherwise, at OFF_TICKS, PLAY_OFF SHALL increment idx and re-enter PLAY_ON.
REQ-029 WAIT_IN SHALL drive seq_led=0 and SHALL treat btn!=0 as a press.
REQ-030 A press equal to onehot(mem[idx]) with idx<len-1 SHALL increment idx and clear the timer.
REQ-031 A matching press with idx==len-1 SHALL set score=len.
REQ-032 After a final matching press, the next state SHALL be WIN if len==MAX_LEN, else ADD.
REQ-033 A press not equal to the expected one-hot (wrong colour or multiple bits) SHALL enter LOSE.
REQ-034 Timer reaching TIMEOUT_TICKS in WAIT_IN SHALL enter LOSE.
REQ-035 If a press and the timeout expiry occur in the same cycle, the press SHALL take priority.
REQ-036 btn SHALL be ignored outside WAIT_IN.
REQ-037 LOSE and WIN SHALL hold score; both SHALL drive seq_led=0.
REQ-038 The LFSR SHALL be 8-bit Fibonacci with taps 8,6,5,4.
REQ-039 The LFSR SHALL free-run every clock in IDLE so that start timing seeds randomness.
REQ-040 Outside IDLE, the LFSR SHALL step only in ADD.

Reset
REQ-041 rst SHALL force IDLE with seq_led=0, score=0, display_loss=0, win=0, busy=0.
REQ-042 rst SHALL also force len=0, idx=0, timer=0 and lfsr=LFSR_SEED.
REQ-043 rst asserted mid-playback or mid-input SHALL take effect next edge, overriding all other inputs.

Structure
REQ-044 A shared package simon_pkg SHALL hold the state enum, the colour_t 2-bit type and the onehot function.
REQ-045 A sub-module simon_lfsr SHALL contain the LFSR (ports clk, rst, en, seed, q[7:0]).
REQ-046 The colour array SHALL be flops, not inferred RAM.

Verification (bench parameters ON=2, OFF=1, TIMEOUT=5, MAX_LEN=3, tick=1 every cycle)
REQ-047 Reset then start: seq_led shows onehot(mem[0]) for 2 cycles, then 0 for 1 cycle, then WAIT_IN; busy=1 throughout; score=0.
REQ-048 Correct replay of all 3 rounds: score steps 1,2,3; after the last press win=1, busy=0, score=3.
REQ-049 Wrong colour on press 2 of round 2: LOSE next cycle; display_loss=1; score stays 1; a later start clears it to 0.
REQ-050 btn=4'b0011 as the first press: LOSE; no press for 5 ticks in WAIT_IN: LOSE; a press coinciding with the 5th tick is accepted.
REQ-051 rst pulsed during PLAY_ON of round 2: next cycle IDLE with all outputs 0; start and btn asserted together with rst are ignored.
